// File: rtl/rv_decode_q.sv
// Instruction queue feeding an RV32I decoder that splits branches and jumps into
// two micro-ops. The head entry is decoded combinationally and presented to execute.
module rv_decode_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [2:0]                 out_type,
    output logic [1:0]                 out_uop,
    output logic [XLEN-1:0]            out_imm,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic                       out_rs1_en,
    output logic                       out_rs2_en,
    output logic                       out_rd_we,
    output logic                       illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [1:0] UOP_CMP    = 2'd0;
    localparam logic [1:0] UOP_TARGET = 2'd1;
    localparam logic [1:0] UOP_RET    = 2'd2;
    localparam logic [1:0] UOP_SINGLE = 2'd3;

    typedef enum logic {
        SEQ_FIRST,
        SEQ_SECOND
    } seq_t;

    seq_t seq_reg, seq_next;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic            head_legal;
    logic            is_branch;
    logic            is_link;
    logic [2:0]      head_type;
    logic [31:0]     imm32;
    logic            nonempty;
    logic            fire;
    logic            last_uop;
    logic            push;
    logic            pop;

    assign head_inst = inst_mem[rd_ptr_reg];
    assign head_pc   = pc_mem[rd_ptr_reg];
    assign nonempty  = (count_reg != '0);

    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = nonempty && head_legal && !flush;
    assign illegal   = nonempty && !head_legal && !flush;
    assign fire      = out_valid && out_ready;
    assign last_uop  = !(is_branch || is_link) || (seq_reg == SEQ_SECOND);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = (fire && last_uop) || illegal;
    assign count     = count_reg;

    // Opcode classification; unknown opcodes are dropped as illegal at the head.
    always_comb begin
        head_legal = 1'b1;
        is_branch  = 1'b0;
        is_link    = 1'b0;
        head_type  = TYPE_R;
        case (head_inst[6:0])
            7'b0110011: head_type = TYPE_R;
            7'b0000011,
            7'b0010011: head_type = TYPE_I;
            7'b1100111: begin
                head_type = TYPE_I;
                is_link   = 1'b1;
            end
            7'b0100011: head_type = TYPE_S;
            7'b1100011: begin
                head_type = TYPE_B;
                is_branch = 1'b1;
            end
            7'b0110111,
            7'b0010111: head_type = TYPE_U;
            7'b1101111: begin
                head_type = TYPE_J;
                is_link   = 1'b1;
            end
            default:    head_legal = 1'b0;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (head_type)
            TYPE_I:  imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
            TYPE_S:  imm32 = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            TYPE_B:  imm32 = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                              head_inst[30:25], head_inst[11:8], 1'b0};
            TYPE_U:  imm32 = {head_inst[31:12], 12'd0};
            TYPE_J:  imm32 = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                              head_inst[20], head_inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        // The return-address micro-op adds the fixed instruction length.
        if (is_link && seq_reg == SEQ_SECOND) begin
            imm32 = 32'd4;
        end
    end

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign out_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_imm_narrow
            assign out_imm = imm32[XLEN-1:0];
        end
    endgenerate

    always_comb begin
        out_pc     = head_pc;
        out_type   = head_type;
        out_rs1    = head_inst[19:15];
        out_rs2    = head_inst[24:20];
        out_rd     = head_inst[11:7];
        out_uop    = UOP_SINGLE;
        out_rs1_en = (head_type != TYPE_U) && (head_type != TYPE_J);
        out_rs2_en = (head_type == TYPE_R) || (head_type == TYPE_S) || (head_type == TYPE_B);
        out_rd_we  = (head_type != TYPE_S) && (head_type != TYPE_B) && (head_inst[11:7] != 5'd0);
        if (is_branch) begin
            out_uop = (seq_reg == SEQ_FIRST) ? UOP_CMP : UOP_TARGET;
        end else if (is_link) begin
            out_uop = (seq_reg == SEQ_FIRST) ? UOP_TARGET : UOP_RET;
            if (seq_reg == SEQ_FIRST) begin
                out_rd_we = 1'b0;
            end
        end
    end

    always_comb begin
        seq_next = seq_reg;
        if (flush) begin
            seq_next = SEQ_FIRST;
        end else if (fire) begin
            case (seq_reg)
                SEQ_FIRST:  if (is_branch || is_link) seq_next = SEQ_SECOND;
                SEQ_SECOND: seq_next = SEQ_FIRST;
                default:    seq_next = SEQ_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_reg <= SEQ_FIRST;
        end else begin
            seq_reg <= seq_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= in_pc;
            inst_mem[wr_ptr_reg] <= in_inst;
        end
    end

endmodule
